f_pcgen: RTL and testbench
==========================

Name: f_pcgen

Overview:
- Fetch-stage PC generator and branch predictor, directly upstream of the decode-stage next-PC/branch-resolve logic.
- Holds the architectural fetch PC and predicts the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Registers pc / pc_predicted / cannot_predict into the IF/ID slot for decode to check.
- Consumes decode's fail_predict and resolved nextpc to redirect fetch and train the BTB.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2. IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  pipeline hold from hazard logic.
- fail_predict  input  1  decode detected misprediction for the instruction in the ID slot.
- d_nextpc  input  32  decode-resolved next PC.
- d_jump_code  input  2  decode instruction class: 00 none, 01 branch, 10 JAL, 11 JALR.
- imem_addr  output  32  current fetch PC to instruction memory (combinational from PC register).
- d_pc  output  32  PC of the instruction in the ID slot (registered).
- d_pc_predicted  output  32  predicted next PC for that instruction (registered).
- d_cannot_predict  output  1  ID slot is a bubble; decode suppresses the check and BTB update (registered).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - d_pc=0, d_pc_predicted=0, d_cannot_predict=1.
  - All BTB valid bits cleared; all counters set to 01 (weakly not-taken).
  - Reset mid-operation discards any pending redirect or update.
- Lookup (combinational on pc):
  - idx=pc[IDX+1:2]; tag=pc[31:IDX+2].
  - Hit = valid[idx] and tag match.
  - pred = target[idx] if hit and (counter[idx]≥2 or kind[idx]=jump), else pc+4.
  - pc+4 wraps modulo 2^32.
- Update condition: upd = !stall and !d_cannot_predict and d_jump_code≠00.
  - taken = (d_nextpc ≠ d_pc+4); index and tag are taken from d_pc.
  - Branch (01), hit: counter ±1, saturating at 00/11. If taken, also rewrite target.
  - Branch (01), miss: allocate only if taken (valid=1, tag, target=d_nextpc, counter=10, kind=branch). Not-taken miss changes nothing.
  - JAL/JALR (10/11): write valid, tag, target=d_nextpc, kind=jump, counter=11; replaces any entry.
  - Same-cycle lookup at the same index reads old contents; the new contents are visible from the next cycle.
- Sequencing at the clock edge:
  - stall=1: pc, ID slot and BTB all hold. fail_predict is ignored while stalled, because decode operands may be stale.
  - !stall and fail_predict:
    - pc ← d_nextpc;
    - d_cannot_predict ← 1 (wrong-path instruction squashed);
    - d_pc and d_pc_predicted ← don't-care, driven 0.
    - Exactly one bubble; the BTB update for the mispredicted instruction still occurs.
  - !stall and !fail_predict: pc ← pred; d_pc ← pc; d_pc_predicted ← pred; d_cannot_predict ← 0.
- Latencies: lookup 0 cycles; redirect 1 cycle to imem_addr; BTB training visible 1 cycle later.
- No misalignment checks: targets are taken as given and bits [1:0] are passed through.

Decomposition:
- Shared package holds:
  - jump_code constants JC_NONE/JC_BRANCH/JC_JAL/JC_JALR (also used by decode);
  - counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - RESET_PC default.
- One sub-module, f_btb: storage arrays, async-reset clear, combinational read port, single write port with counter saturation.
- f_pcgen keeps the PC register, the IF/ID slot registers and the redirect/stall priority logic.

Test Plan:
- Reset/sequential: hold rst_n=0, then release with no branches.
  - During reset: imem_addr=0, d_cannot_predict=1.
  - Then imem_addr 0,4,8,C on successive edges; d_pc lags by one cycle; d_pc_predicted=d_pc+4.
- Cold taken branch: at d_pc=0x10, d_jump_code=01, d_nextpc=0x40, fail_predict=1.
  - Next cycle: imem_addr=0x40, d_cannot_predict=1.
  - BTB[4]: valid, target 0x40, counter 10.
- Trained hit: refetch 0x10.
  - d_pc_predicted=0x40; next imem_addr=0x40 with no bubble.
  - Three not-taken resolutions drive the counter 10→01→00; prediction becomes 0x14.
- Stall priority: fail_predict=1 with stall=1 for 3 cycles.
  - pc, ID slot and BTB are unchanged.
  - stall drops while fail_predict is still 1: redirect applies on that edge.
- Aliasing/JALR (BTB_ENTRIES=16):
  - JALR at 0x50 to 0x200 overwrites the entry at index 4.
  - Fetch 0x10 then misses (tag mismatch) and predicts 0x14; fetch 0x50 predicts 0x200.
  - Wrap-around: pc=0xFFFF_FFFC with no hit gives next imem_addr=0.
- Async reset mid-redirect: assert rst_n=0 between edges while fail_predict=1.
  - imem_addr=RESET_PC immediately; BTB hit on 0x10 is gone after release.

Source files
------------

// File: rtl/f_pcgen_pkg.sv
// Shared types and constants for the fetch-stage PC generator and its BTB.
// Jump-class codes are also consumed by the decode-stage resolve logic.
package f_pcgen_pkg;

   typedef enum logic [1:0] {
      JC_NONE   = 2'b00,
      JC_BRANCH = 2'b01,
      JC_JAL    = 2'b10,
      JC_JALR   = 2'b11
   } jump_code_t;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   typedef enum logic {
      KIND_BRANCH = 1'b0,
      KIND_JUMP   = 1'b1
   } btb_kind_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic ctr_t ctr_train(input ctr_t c, input logic taken);
      ctr_t r;
      r = c;
      if (taken && (c != ST)) begin
         r = ctr_t'(c + 2'd1);
      end else if (!taken && (c != SNT)) begin
         r = ctr_t'(c - 2'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/f_pcgen_btb.sv
// Direct-mapped branch target buffer: combinational read port on the fetch PC,
// one write port driven by the decode-stage resolution.
module f_btb
   import f_pcgen_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:2] rd_pc,
   output logic        rd_hit,
   output logic [31:0] rd_target,
   output ctr_t        rd_ctr,
   output btb_kind_t   rd_kind,
   input  logic        wr_en,
   input  jump_code_t  wr_code,
   input  logic [31:2] wr_pc,
   input  logic        wr_taken,
   input  logic [31:0] wr_target
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = 32 - IDX - 2;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag    [ENTRIES];
   logic [31:0]        target [ENTRIES];
   ctr_t               ctr    [ENTRIES];
   btb_kind_t          kind   [ENTRIES];

   logic [IDX-1:0]     rd_idx;
   logic [IDX-1:0]     wr_idx;
   logic [TAG_W-1:0]   rd_tag;
   logic [TAG_W-1:0]   wr_tag;
   logic               wr_hit;

   assign rd_idx    = rd_pc[IDX+1:2];
   assign rd_tag    = rd_pc[31:IDX+2];
   assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
   assign rd_target = target[rd_idx];
   assign rd_ctr    = ctr[rd_idx];
   assign rd_kind   = kind[rd_idx];

   assign wr_idx    = wr_pc[IDX+1:2];
   assign wr_tag    = wr_pc[31:IDX+2];
   assign wr_hit    = valid[wr_idx] && (tag[wr_idx] == wr_tag);

   // Branches only allocate on a taken miss; jumps always claim the entry as
   // strongly taken so aliasing branches lose their slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag[i]    <= '0;
            target[i] <= '0;
            ctr[i]    <= WNT;
            kind[i]   <= KIND_BRANCH;
         end
      end else if (wr_en) begin
         if (wr_code == JC_BRANCH) begin
            if (wr_hit) begin
               ctr[wr_idx] <= ctr_train(ctr[wr_idx], wr_taken);
               if (wr_taken) begin
                  target[wr_idx] <= wr_target;
               end
            end else if (wr_taken) begin
               valid[wr_idx]  <= 1'b1;
               tag[wr_idx]    <= wr_tag;
               target[wr_idx] <= wr_target;
               ctr[wr_idx]    <= WT;
               kind[wr_idx]   <= KIND_BRANCH;
            end
         end else if ((wr_code == JC_JAL) || (wr_code == JC_JALR)) begin
            valid[wr_idx]  <= 1'b1;
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= wr_target;
            ctr[wr_idx]    <= ST;
            kind[wr_idx]   <= KIND_JUMP;
         end
      end
   end

endmodule

// File: rtl/f_pcgen.sv
// Fetch PC generator: holds the fetch PC, predicts the next PC from the BTB and
// fills the IF/ID slot that decode checks against the resolved next PC.
module f_pcgen
   import f_pcgen_pkg::*;
#(
   parameter int          BTB_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        fail_predict,
   input  logic [31:0] d_nextpc,
   input  logic [1:0]  d_jump_code,
   output logic [31:0] imem_addr,
   output logic [31:0] d_pc,
   output logic [31:0] d_pc_predicted,
   output logic        d_cannot_predict
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] pred;
   logic        rd_hit;
   logic [31:0] rd_target;
   ctr_t        rd_ctr;
   btb_kind_t   rd_kind;
   logic        upd;
   logic        taken;

   f_btb #(
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_pc     (pc[31:2]),
      .rd_hit    (rd_hit),
      .rd_target (rd_target),
      .rd_ctr    (rd_ctr),
      .rd_kind   (rd_kind),
      .wr_en     (upd),
      .wr_code   (jump_code_t'(d_jump_code)),
      .wr_pc     (d_pc[31:2]),
      .wr_taken  (taken),
      .wr_target (d_nextpc)
   );

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign pred      = (rd_hit && ((rd_ctr inside {WT, ST}) || (rd_kind == KIND_JUMP)))
                      ? rd_target : pc_plus4;

   // Bubbles in the ID slot carry no resolved outcome, so they never train.
   assign upd   = !stall && !d_cannot_predict && (d_jump_code != JC_NONE);
   assign taken = (d_nextpc != (d_pc + 32'd4));

   // A stall freezes everything, including redirects, since decode operands may be stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc               <= RESET_PC;
         d_pc             <= '0;
         d_pc_predicted   <= '0;
         d_cannot_predict <= 1'b1;
      end else if (!stall) begin
         if (fail_predict) begin
            pc               <= d_nextpc;
            d_pc             <= '0;
            d_pc_predicted   <= '0;
            d_cannot_predict <= 1'b1;
         end else begin
            pc               <= pred;
            d_pc             <= pc;
            d_pc_predicted   <= pred;
            d_cannot_predict <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_f_pcgen.sv
// Self-checking bench for f_pcgen: directed scenarios followed by random traffic,
// all compared against a table-based behavioural model of fetch and the BTB.
module tb_f_pcgen;
   import f_pcgen_pkg::*;

   localparam int          N      = 16;
   localparam int          IDXW   = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        fail_predict = 1'b0;
   logic [31:0] d_nextpc = '0;
   logic [1:0]  d_jump_code = '0;
   logic [31:0] imem_addr;
   logic [31:0] d_pc;
   logic [31:0] d_pc_predicted;
   logic        d_cannot_predict;

   int n_cmp = 0;
   int n_fail = 0;

   bit          m_valid  [N];
   logic [31:0] m_tag    [N];
   logic [31:0] m_target [N];
   int          m_ctr    [N];
   bit          m_jump   [N];
   logic [31:0] m_pc;
   logic [31:0] m_dpc;
   logic [31:0] m_dpred;
   bit          m_dcp;

   logic [31:0] pool [6];

   always #5 clk = ~clk;

   f_pcgen #(
      .BTB_ENTRIES (N),
      .RESET_PC    (RST_PC)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .fail_predict     (fail_predict),
      .d_nextpc         (d_nextpc),
      .d_jump_code      (d_jump_code),
      .imem_addr        (imem_addr),
      .d_pc             (d_pc),
      .d_pc_predicted   (d_pc_predicted),
      .d_cannot_predict (d_cannot_predict)
   );

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) % N);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] a);
      return a >> (IDXW + 2);
   endfunction

   function automatic logic [31:0] model_pred(input logic [31:0] a);
      int i;
      i = idx_of(a);
      if (m_valid[i] && (m_tag[i] == tag_of(a)) && ((m_ctr[i] >= 2) || m_jump[i]))
         return m_target[i];
      return a + 32'd4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = '0;
         m_target[i] = '0;
         m_ctr[i]    = 1;
         m_jump[i]   = 1'b0;
      end
      m_pc    = RST_PC;
      m_dpc   = '0;
      m_dpred = '0;
      m_dcp   = 1'b1;
   endtask

   task automatic model_train(input logic [31:0] a, input logic [31:0] np, input logic [1:0] jc);
      int i;
      bit hit;
      bit tk;
      i   = idx_of(a);
      hit = m_valid[i] && (m_tag[i] == tag_of(a));
      tk  = (np != a + 32'd4);
      if (jc == 2'd1) begin
         if (hit) begin
            if (tk) begin
               if (m_ctr[i] < 3) m_ctr[i]++;
               m_target[i] = np;
            end else if (m_ctr[i] > 0) begin
               m_ctr[i]--;
            end
         end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = tag_of(a);
            m_target[i] = np;
            m_ctr[i]    = 2;
            m_jump[i]   = 1'b0;
         end
      end else if (jc != 2'd0) begin
         m_valid[i]  = 1'b1;
         m_tag[i]    = tag_of(a);
         m_target[i] = np;
         m_ctr[i]    = 3;
         m_jump[i]   = 1'b1;
      end
   endtask

   task automatic model_edge(input bit st, input bit fp, input logic [31:0] np, input logic [1:0] jc);
      logic [31:0] p;
      if (st) return;
      p = model_pred(m_pc);
      if (!m_dcp && (jc != 2'd0)) model_train(m_dpc, np, jc);
      if (fp) begin
         m_pc    = np;
         m_dpc   = '0;
         m_dpred = '0;
         m_dcp   = 1'b1;
      end else begin
         m_dpc   = m_pc;
         m_dpred = p;
         m_pc    = p;
         m_dcp   = 1'b0;
      end
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".imem_addr"}, imem_addr, m_pc);
      checkValue({tag, ".d_pc"}, d_pc, m_dpc);
      checkValue({tag, ".d_pc_predicted"}, d_pc_predicted, m_dpred);
      checkValue({tag, ".d_cannot_predict"}, {31'b0, d_cannot_predict}, {31'b0, m_dcp});
   endtask

   task automatic applyStimulus(input bit st, input bit fp, input logic [31:0] np,
                                input logic [1:0] jc, input string tag);
      stall        = st;
      fail_predict = fp;
      d_nextpc     = np;
      d_jump_code  = jc;
      @(posedge clk);
      model_edge(st, fp, np, jc);
      #1;
      checkOutput(tag);
   endtask

   task automatic redirectTo(input logic [31:0] a, input string tag);
      applyStimulus(1'b0, 1'b1, a, 2'd0, {tag, ".redir"});
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, {tag, ".fetch"});
   endtask

   initial begin
      logic [31:0] np;
      bit          st;
      bit          fp;
      logic [1:0]  jc;

      pool[0] = 32'h0000_0010;
      pool[1] = 32'h0000_0040;
      pool[2] = 32'h0000_0050;
      pool[3] = 32'h0000_0200;
      pool[4] = 32'h1000_0010;
      pool[5] = 32'hFFFF_FFF8;

      // Reset and sequential fetch
      rst_n = 1'b0;
      model_reset();
      #12;
      checkOutput("reset");
      checkValue("reset.imem_const", imem_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, "seq");
      checkValue("seq.imem_10", imem_addr, 32'h10);
      checkValue("seq.dpc_0c", d_pc, 32'h0C);
      checkValue("seq.dpred_10", d_pc_predicted, 32'h10);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, "seq");

      // Cold taken branch at 0x10 -> 0x40
      applyStimulus(1'b0, 1'b1, 32'h40, 2'd1, "cold");
      checkValue("cold.imem_40", imem_addr, 32'h40);
      checkValue("cold.bubble", {31'b0, d_cannot_predict}, 32'h1);

      // Trained hit, then three not-taken resolutions
      redirectTo(32'h10, "hit");
      checkValue("hit.dpred_40", d_pc_predicted, 32'h40);
      checkValue("hit.imem_40", imem_addr, 32'h40);
      applyStimulus(1'b0, 1'b1, 32'h14, 2'd1, "nt1");
      redirectTo(32'h10, "nt2");
      checkValue("nt2.dpred_14", d_pc_predicted, 32'h14);
      applyStimulus(1'b0, 1'b0, 32'h14, 2'd1, "nt2.res");
      redirectTo(32'h10, "nt3");
      applyStimulus(1'b0, 1'b0, 32'h14, 2'd1, "nt3.res");
      redirectTo(32'h10, "nt3.chk");
      checkValue("nt3.dpred_14", d_pc_predicted, 32'h14);

      // Stall holds off a pending redirect and its BTB update
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 32'h300, 2'd1, "stall");
      checkValue("stall.dpc_10", d_pc, 32'h10);
      checkValue("stall.imem_14", imem_addr, 32'h14);
      applyStimulus(1'b0, 1'b1, 32'h300, 2'd1, "unstall");
      checkValue("unstall.imem_300", imem_addr, 32'h300);
      redirectTo(32'h10, "stall.train");
      checkValue("stall.train_once", d_pc_predicted, 32'h14);

      // JALR alias at index 4, then wrap-around
      redirectTo(32'h50, "jalr");
      applyStimulus(1'b0, 1'b1, 32'h200, 2'd3, "jalr.res");
      redirectTo(32'h10, "alias");
      checkValue("alias.dpred_14", d_pc_predicted, 32'h14);
      redirectTo(32'h50, "jalr.hit");
      checkValue("jalr.dpred_200", d_pc_predicted, 32'h200);
      checkValue("jalr.imem_200", imem_addr, 32'h200);
      redirectTo(32'hFFFF_FFFC, "wrap");
      checkValue("wrap.imem_0", imem_addr, 32'h0);

      // Async reset while a redirect is pending
      redirectTo(32'h10, "retrain");
      applyStimulus(1'b0, 1'b1, 32'h40, 2'd1, "retrain.res");
      redirectTo(32'h10, "retrain.chk");
      checkValue("retrain.dpred_40", d_pc_predicted, 32'h40);
      fail_predict = 1'b1;
      d_nextpc     = 32'h80;
      d_jump_code  = 2'd1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checkOutput("areset");
      checkValue("areset.imem_rst", imem_addr, RST_PC);
      @(posedge clk);
      #1;
      checkOutput("areset.hold");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, "post");
      checkValue("post.dpc_10", d_pc, 32'h10);
      checkValue("post.dpred_14", d_pc_predicted, 32'h14);

      // Random traffic against the model
      $display("[TB] random phase");
      for (int k = 0; k < 400; k++) begin
         st = ($urandom_range(0, 99) < 15);
         jc = 2'($urandom_range(0, 3));
         if (m_dcp) begin
            np = pool[$urandom_range(0, 5)];
            fp = ($urandom_range(0, 3) == 0);
         end else begin
            np = ($urandom_range(0, 1) == 1) ? (m_dpc + 32'd4) : pool[$urandom_range(0, 5)];
            fp = (np != m_dpred);
         end
         applyStimulus(st, fp, np, jc, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
